sys_array_seq: RTL and testbench
================================

Name: sys_array_seq

Overview:
- Layer sequencer for the 3x3 systolic convolution array.
- On start, fetches 9 kernel weights and then a SIZE x SIZE input tile from a synchronous buffer memory, and streams them into the array's weight/input load ports.
- Counts the (SIZE-2)^2 ReLU6 results the array returns, forwards them with a row-major index, and reports done or timeout to the host.

Parameters:
- SIZE, 7, tile edge length; the output map is (SIZE-2) x (SIZE-2).
- ADDR_W, 12, buffer memory address width.
- TIMEOUT, 255, maximum idle cycles allowed between results before error is raised.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; launches a layer when idle
- w_base  in  ADDR_W  weight base address, sampled on accepted start
- i_base  in  ADDR_W  input tile base address, sampled on accepted start
- busy  out  1  high from accepted start until done/error
- done  out  1  one-cycle pulse after the last result is forwarded
- error  out  1  sticky timeout flag, cleared by next accepted start
- mem_rd_en  out  1  buffer read strobe
- mem_addr  out  ADDR_W  buffer read address
- mem_rdata  in  16  signed read data, valid exactly 1 cycle after mem_rd_en
- w_load  out  1  weight-valid strobe to array
- w_in  out  16  signed weight word
- i_load  out  1  input-valid strobe to array
- i_in  out  16  signed input word
- arr_result  in  16  array result (already ReLU6-clamped)
- arr_res_sig  in  1  array result-valid
- out_valid  out  1  forwarded result valid
- out_data  out  16  forwarded result
- out_idx  out  8  row-major output index, 0..(SIZE-2)^2-1

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0.
- Reset is honoured mid-layer: the sequencer returns to IDLE immediately and no done pulse is emitted.
- States: IDLE, FETCH_W, FETCH_I, DRAIN, FINISH.
- IDLE:
  - start accepted: latch both bases, clear error, busy<=1, go to FETCH_W.
  - start while busy is ignored.
- FETCH_W:
  - mem_rd_en=1 for exactly 9 consecutive cycles, mem_addr = w_base+0..8.
  - Then FETCH_I with no bubble.
- FETCH_I:
  - mem_rd_en=1 for SIZE*SIZE consecutive cycles, mem_addr = i_base+0..SIZE*SIZE-1 (row-major).
  - Then DRAIN.
- Load strobes are registered copies of the read strobe, 1 cycle later:
  - w_load = delayed weight read, with w_in = mem_rdata.
  - i_load = delayed input read, with i_in = mem_rdata.
  - w_load and i_load are never high together.
  - The first i_load immediately follows the last w_load.
- Address arithmetic wraps modulo 2^ADDR_W; no error is raised on wrap.
- Result capture is active in FETCH_I and DRAIN, because the array emits results while inputs are still streaming.
  - Each cycle with arr_res_sig=1 registers out_valid=1, out_data=arr_result, out_idx=result count; the count then increments.
  - arr_res_sig outside FETCH_I/DRAIN, or beyond (SIZE-2)^2 results, is dropped.
- DRAIN:
  - When the result count reaches (SIZE-2)^2, go to FINISH.
  - Timeout counter resets on every captured result. If it reaches TIMEOUT: error<=1, busy<=0, go to IDLE, no done pulse.
- FINISH: done=1 for one cycle, busy<=0, go to IDLE.
- Latency for SIZE=7:
  - First w_load at start+2.
  - Last i_load at start+1+9+49.
- Counters are sized by $clog2 of their maximum value; out_idx is zero-extended to 8 bits.

Optional Feature:
- Macro: SYS_ARRAY_SEQ_PERF_EN.
- When defined:
  - Adds output port cycle_cnt [31:0], counting clk cycles while busy.
  - cycle_cnt is cleared on accepted start, frozen at done/error, and holds its value until the next start.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - State encoding enum: IDLE, FETCH_W, FETCH_I, DRAIN, FINISH.
  - Constants KERNEL_TAPS=9 and DATA_W=16.
  - Function for output count (SIZE-2)^2.
- One sub-module, seq_rd_stream: address generator plus 1-cycle strobe delay. Inputs: base, length, go. Outputs: rd_en, addr, data_valid, last. Instantiated once and reused for the weight and input phases.

Test Plan:
- Nominal: SIZE=7, w_base=0x010, i_base=0x100, memory model with 1-cycle latency, array model returning 25 results -> 9 w_load then 49 i_load back-to-back; 25 out_valid with out_idx 0..24; done pulse one cycle after out_idx=24; busy low after done.
- Start while busy: second start pulsed during FETCH_I with different bases -> ignored; addresses unchanged; exactly one done.
- Timeout: TIMEOUT=20, array model stops after 10 results -> error=1 and busy=0 on the 20th idle cycle; no done; next start clears error.
- Reset mid-layer: rst_n asserted during FETCH_I at input word 30 -> all outputs 0 immediately; a subsequent start runs a full clean layer with out_idx restarting at 0.
- Address wrap: ADDR_W=8, i_base=0xF0 -> mem_addr sequence 0xF0..0xFF, 0x00..0x20; data streamed correctly.
- Spurious result: arr_res_sig pulsed in IDLE and as a 26th result -> no out_valid; count unaffected.

Source files
------------

// File: rtl/sys_array_seq_pkg.sv
// Shared types and constants for the systolic-array layer sequencer.
package sys_array_seq_pkg;

   localparam int unsigned KERNEL_TAPS = 9;
   localparam int unsigned DATA_W      = 16;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH_W = 3'd1,
      FETCH_I = 3'd2,
      DRAIN   = 3'd3,
      FINISH  = 3'd4
   } seq_state_e;

   // Number of valid 3x3 convolution outputs for a size x size tile.
   function automatic int unsigned out_count(input int unsigned size);
      return (size - 2) * (size - 2);
   endfunction

endpackage

// File: rtl/seq_rd_stream.sv
// Burst read address generator: issues len consecutive reads from base and
// delays the read strobe by one cycle to mark returning data.
module seq_rd_stream #(
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned LEN_W  = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] base_i,
   input  logic [LEN_W-1:0]  len_i,
   input  logic              go_i,
   output logic              rd_en_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic              data_valid_o,
   output logic              last_o
);

   logic              rd_en_q, rd_en_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic              dv_q;

   assign last_o = rd_en_q && (cnt_q == len_q - LEN_W'(1));

   // A go on the final beat restarts immediately, giving gapless back-to-back bursts.
   always_comb begin
      rd_en_d = rd_en_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      if (go_i) begin
         rd_en_d = 1'b1;
         addr_d  = base_i;
         cnt_d   = '0;
         len_d   = len_i;
      end else if (rd_en_q) begin
         if (last_o) begin
            rd_en_d = 1'b0;
         end else begin
            addr_d = addr_q + ADDR_W'(1);
            cnt_d  = cnt_q + LEN_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_en_q <= 1'b0;
         addr_q  <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
         dv_q    <= 1'b0;
      end else begin
         rd_en_q <= rd_en_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         dv_q    <= rd_en_q;
      end
   end

   assign rd_en_o      = rd_en_q;
   assign addr_o       = addr_q;
   assign data_valid_o = dv_q;

endmodule

// File: rtl/sys_array_seq.sv
// Layer sequencer for the 3x3 systolic array: streams weights then an input tile,
// forwards indexed results. Define SYS_ARRAY_SEQ_PERF_EN to add the cycle_cnt_o busy counter.
module sys_array_seq
   import sys_array_seq_pkg::*;
#(
   parameter int unsigned SIZE    = 7,
   parameter int unsigned ADDR_W  = 12,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] w_base_i,
   input  logic [ADDR_W-1:0] i_base_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              error_o,
   output logic              mem_rd_en_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              w_load_o,
   output logic [DATA_W-1:0] w_in_o,
   output logic              i_load_o,
   output logic [DATA_W-1:0] i_in_o,
   input  logic [DATA_W-1:0] arr_result_i,
   input  logic              arr_res_sig_i,
   output logic              out_valid_o,
   output logic [DATA_W-1:0] out_data_o,
   output logic [7:0]        out_idx_o
`ifdef SYS_ARRAY_SEQ_PERF_EN
   ,
   output logic [31:0]       cycle_cnt_o
`endif
);

   localparam int unsigned TILE  = SIZE * SIZE;
   localparam int unsigned N_OUT = out_count(SIZE);
   localparam int unsigned LEN_W = $clog2(TILE + 1);
   localparam int unsigned RES_W = $clog2(N_OUT + 1);
   localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

   seq_state_e        state_q, state_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              error_q, error_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [7:0]        out_idx_q, out_idx_d;
   logic [RES_W-1:0]  res_cnt_q, res_cnt_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic [ADDR_W-1:0] i_base_q, i_base_d;
   logic              phase_w_q, phase_w_d;

   logic              go_c;
   logic [ADDR_W-1:0] base_c;
   logic [LEN_W-1:0]  len_c;
   logic              rd_en, rd_dv, rd_last;
   logic [ADDR_W-1:0] rd_addr;
   logic              cap_c, all_res_c, tmo_expire_c;

   seq_rd_stream #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_rd (
      .clk          (clk),
      .rst_n        (rst_n),
      .base_i       (base_c),
      .len_i        (len_c),
      .go_i         (go_c),
      .rd_en_o      (rd_en),
      .addr_o       (rd_addr),
      .data_valid_o (rd_dv),
      .last_o       (rd_last)
   );

   // Results may arrive while inputs still stream, so capture spans FETCH_I and DRAIN.
   assign all_res_c    = (res_cnt_q == RES_W'(N_OUT));
   assign cap_c        = arr_res_sig_i && !all_res_c &&
                         (state_q == FETCH_I || state_q == DRAIN);
   assign tmo_expire_c = !cap_c && (tmo_q == TMO_W'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_i) state_d = FETCH_W;
         FETCH_W: if (rd_last) state_d = FETCH_I;
         FETCH_I: if (rd_last) state_d = DRAIN;
         DRAIN: begin
            if (all_res_c)         state_d = FINISH;
            else if (tmo_expire_c) state_d = IDLE;
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Weight base goes straight into the stream's address register on the accepting edge.
   always_comb begin
      busy_d      = busy_q;
      done_d      = 1'b0;
      error_d     = error_q;
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
      out_idx_d   = out_idx_q;
      res_cnt_d   = res_cnt_q;
      tmo_d       = '0;
      i_base_d    = i_base_q;
      phase_w_d   = (state_q == FETCH_W);
      go_c        = 1'b0;
      base_c      = i_base_q;
      len_c       = LEN_W'(TILE);
      if (cap_c) begin
         out_valid_d = 1'b1;
         out_data_d  = arr_result_i;
         out_idx_d   = 8'(res_cnt_q);
         res_cnt_d   = res_cnt_q + RES_W'(1);
      end
      case (state_q)
         IDLE: begin
            if (start_i) begin
               busy_d    = 1'b1;
               error_d   = 1'b0;
               i_base_d  = i_base_i;
               res_cnt_d = '0;
               go_c      = 1'b1;
               base_c    = w_base_i;
               len_c     = LEN_W'(KERNEL_TAPS);
            end
         end
         FETCH_W: go_c = rd_last;
         DRAIN: begin
            if (all_res_c) begin
               done_d = 1'b1;
               busy_d = 1'b0;
            end else if (tmo_expire_c) begin
               error_d = 1'b1;
               busy_d  = 1'b0;
            end else if (!cap_c) begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_idx_q   <= '0;
         res_cnt_q   <= '0;
         tmo_q       <= '0;
         i_base_q    <= '0;
         phase_w_q   <= 1'b0;
      end else begin
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_idx_q   <= out_idx_d;
         res_cnt_q   <= res_cnt_d;
         tmo_q       <= tmo_d;
         i_base_q    <= i_base_d;
         phase_w_q   <= phase_w_d;
      end
   end

   // Read data lands in the cycle after the strobe, so the load words pass straight through.
   assign w_load_o    = rd_dv && phase_w_q;
   assign i_load_o    = rd_dv && !phase_w_q;
   assign w_in_o      = w_load_o ? mem_rdata_i : '0;
   assign i_in_o      = i_load_o ? mem_rdata_i : '0;
   assign mem_rd_en_o = rd_en;
   assign mem_addr_o  = rd_addr;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign error_o     = error_q;
   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;
   assign out_idx_o   = out_idx_q;

`ifdef SYS_ARRAY_SEQ_PERF_EN
   logic [31:0] cycle_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                           cycle_cnt_q <= '0;
      else if (state_q == IDLE && start_i)  cycle_cnt_q <= '0;
      else if (busy_q)                      cycle_cnt_q <= cycle_cnt_q + 32'd1;
   end

   assign cycle_cnt_o = cycle_cnt_q;
`endif

endmodule

// File: tb/tb_sys_array_seq.sv
// Directed bench for sys_array_seq (SIZE=7, ADDR_W=12, TIMEOUT=20) with memory and array models.
module tb_sys_array_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [11:0] w_base = '0;
   logic [11:0] i_base = '0;
   logic        busy, done, error, mem_rd_en;
   logic [11:0] mem_addr;
   logic [15:0] mem_rdata = '0;
   logic        w_load, i_load;
   logic [15:0] w_in, i_in;
   logic [15:0] arr_result;
   logic        arr_res_sig;
   logic        out_valid;
   logic [15:0] out_data;
   logic [7:0]  out_idx;
`ifdef SYS_ARRAY_SEQ_PERF_EN
   logic [31:0] cycle_cnt;
`endif

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sys_array_seq #(.SIZE(7), .ADDR_W(12), .TIMEOUT(20)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start), .w_base_i(w_base), .i_base_i(i_base),
      .busy_o(busy), .done_o(done), .error_o(error),
      .mem_rd_en_o(mem_rd_en), .mem_addr_o(mem_addr), .mem_rdata_i(mem_rdata),
      .w_load_o(w_load), .w_in_o(w_in), .i_load_o(i_load), .i_in_o(i_in),
      .arr_result_i(arr_result), .arr_res_sig_i(arr_res_sig),
      .out_valid_o(out_valid), .out_data_o(out_data), .out_idx_o(out_idx)
`ifdef SYS_ARRAY_SEQ_PERF_EN
      , .cycle_cnt_o(cycle_cnt)
`endif
   );

   function automatic logic [15:0] mem_val(input logic [11:0] a);
      return {4'b0, a} * 16'd37 + 16'h1357;
   endfunction

   function automatic logic [15:0] res_val(input int k);
      return 16'(k * 3 + 1);
   endfunction

   // Synchronous buffer memory, one-cycle read latency.
   always @(posedge clk) if (mem_rd_en) mem_rdata <= mem_val(mem_addr);

   // Array model: one result per valid 3x3 window, the cycle after its last input arrives.
   int          res_limit = 25;
   int          m_icnt, m_issued;
   logic        m_sig;
   logic [15:0] m_res;
   logic        spur = 1'b0;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_icnt <= 0; m_issued <= 0; m_sig <= 1'b0; m_res <= '0;
      end else begin
         m_sig <= 1'b0;
         if (!busy) begin
            m_icnt <= 0; m_issued <= 0;
         end else if (i_load) begin
            m_icnt <= m_icnt + 1;
            if (m_icnt / 7 >= 2 && m_icnt % 7 >= 2 && m_issued < res_limit) begin
               m_sig <= 1'b1; m_res <= res_val(m_issued); m_issued <= m_issued + 1;
            end
         end
      end
   end
   assign arr_res_sig = m_sig | spur;
   assign arr_result  = spur ? 16'h0777 : m_res;

   logic [11:0] addr_log [0:127];
   logic [15:0] w_log [0:15];
   logic [15:0] i_log [0:63];
   logic [15:0] o_data [0:63];
   logic [7:0]  o_idx [0:63];
   int n_addr, n_w, n_i, n_o, n_done, n_both;
   int first_w, first_i, last_i, last_o, done_c, err_c;
   logic busy_at_done, busy_at_err, timed_out;
   logic [74:0] rst_snap;

   // Mismatch counters against the expected address / data / result streams.
   function automatic int addr_errs(input logic [11:0] wb, input logic [11:0] ib);
      int e = 0;
      for (int k = 0; k < 58; k++)
         if (addr_log[k] !== ((k < 9) ? wb + 12'(k) : ib + 12'(k - 9))) e++;
      return e;
   endfunction

   function automatic int data_errs(input logic [11:0] wb, input logic [11:0] ib);
      int e = 0;
      for (int k = 0; k < 9; k++)  if (w_log[k] !== mem_val(wb + 12'(k))) e++;
      for (int k = 0; k < 49; k++) if (i_log[k] !== mem_val(ib + 12'(k))) e++;
      return e;
   endfunction

   function automatic int out_errs(input int n);
      int e = 0;
      for (int k = 0; k < n; k++)
         if (o_idx[k] !== 8'(k) || o_data[k] !== res_val(k)) e++;
      return e;
   endfunction

   // Pulse start and log every DUT event by cycle offset from the start cycle.
   // mode 1: second start mid-FETCH_I; mode 2: reset at input word 30; mode 3: extra result after #24.
   task automatic run_layer(input logic [11:0] wb, input logic [11:0] ib, input int mode);
      int tail = -1;
      n_addr = 0; n_w = 0; n_i = 0; n_o = 0; n_done = 0; n_both = 0;
      first_w = -1; first_i = -1; last_i = -1; last_o = -1; done_c = -1; err_c = -1;
      busy_at_done = 1'b1; busy_at_err = 1'b1; timed_out = 1'b0; rst_snap = '1;
      @(negedge clk); w_base = wb; i_base = ib; start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int rel = 1; rel < 300; rel++) begin
         if (mem_rd_en) begin if (n_addr < 128) addr_log[n_addr] = mem_addr; n_addr++; end
         if (w_load) begin if (n_w < 16) w_log[n_w] = w_in; if (first_w < 0) first_w = rel; n_w++; end
         if (i_load) begin if (n_i < 64) i_log[n_i] = i_in; if (first_i < 0) first_i = rel; last_i = rel; n_i++; end
         if (w_load && i_load) n_both++;
         if (out_valid) begin
            if (n_o < 64) begin o_data[n_o] = out_data; o_idx[n_o] = out_idx; end
            last_o = rel; n_o++;
         end
         if (done) begin n_done++; done_c = rel; busy_at_done = busy; end
         if (error && err_c < 0) begin err_c = rel; busy_at_err = busy; end
         if (mode == 1 && rel == 20) begin start = 1'b1; w_base = 12'h0AA; i_base = 12'h0BB; end
         if (mode == 1 && rel == 21) start = 1'b0;
         if (mode == 2 && mem_rd_en && mem_addr == ib + 12'd30) begin
            rst_n = 1'b0;
            #1;
            rst_snap = {busy, done, error, mem_rd_en, mem_addr, w_load, w_in, i_load, i_in,
                        out_valid, out_data, out_idx};
            return;
         end
         if (mode == 3) spur = out_valid && out_idx == 8'd24;
         if (tail < 0 && (done || error)) tail = rel + 4;
         if (rel == tail) return;
         @(negedge clk);
      end
      timed_out = 1'b1;
   endtask

   task automatic test_reset();
      logic [74:0] snap;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      snap = {busy, done, error, mem_rd_en, mem_addr, w_load, w_in, i_load, i_in, out_valid, out_data, out_idx};
      checks++; if (snap !== '0) begin failures++; $display("FAIL reset_held: outputs=%h expected 0", snap); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      snap = {busy, done, error, mem_rd_en, mem_addr, w_load, w_in, i_load, i_in, out_valid, out_data, out_idx};
      checks++; if (snap !== '0) begin failures++; $display("FAIL reset_idle: outputs=%h expected 0", snap); end
   endtask

   task automatic test_nominal();
      int e;
      res_limit = 25;
      run_layer(12'h010, 12'h100, 0);
      checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL nom_budget: no done within budget"); end
      checks++; if (n_addr !== 58) begin failures++; $display("FAIL nom_reads: got %0d expected 58", n_addr); end
      e = addr_errs(12'h010, 12'h100);
      checks++; if (e !== 0) begin failures++; $display("FAIL nom_addr: %0d bad addresses, expected 0", e); end
      checks++; if (n_w !== 9 || n_i !== 49) begin failures++; $display("FAIL nom_loads: w=%0d i=%0d expected 9/49", n_w, n_i); end
      e = data_errs(12'h010, 12'h100);
      checks++; if (e !== 0) begin failures++; $display("FAIL nom_data: %0d bad words, expected 0", e); end
      checks++; if (first_w !== 2) begin failures++; $display("FAIL nom_first_w: cycle %0d expected 2", first_w); end
      checks++; if (first_i !== 11) begin failures++; $display("FAIL nom_first_i: cycle %0d expected 11", first_i); end
      checks++; if (last_i !== 59) begin failures++; $display("FAIL nom_last_i: cycle %0d expected 59", last_i); end
      checks++; if (n_both !== 0) begin failures++; $display("FAIL nom_overlap: %0d cycles expected 0", n_both); end
      checks++; if (n_o !== 25) begin failures++; $display("FAIL nom_results: got %0d expected 25", n_o); end
      e = out_errs(25);
      checks++; if (e !== 0) begin failures++; $display("FAIL nom_out: %0d bad results, expected 0", e); end
      checks++; if (last_o !== 61 || done_c !== 62) begin failures++; $display("FAIL nom_done_time: last_out=%0d done=%0d expected 61/62", last_o, done_c); end
      checks++; if (n_done !== 1 || busy_at_done !== 1'b0) begin failures++; $display("FAIL nom_done: pulses=%0d busy=%b expected 1/0", n_done, busy_at_done); end
      checks++; if (err_c !== -1) begin failures++; $display("FAIL nom_error: error at %0d expected none", err_c); end
`ifdef SYS_ARRAY_SEQ_PERF_EN
      checks++; if (cycle_cnt !== 32'd61) begin failures++; $display("FAIL nom_cycles: got %0d expected 61", cycle_cnt); end
`endif
   endtask

   task automatic test_start_busy();
      int e;
      res_limit = 25;
      run_layer(12'h010, 12'h100, 1);
      e = addr_errs(12'h010, 12'h100);
      checks++; if (e !== 0 || n_addr !== 58) begin failures++; $display("FAIL busy_addr: %0d bad of %0d reads, expected 0 of 58", e, n_addr); end
      checks++; if (n_done !== 1 || done_c !== 62) begin failures++; $display("FAIL busy_done: pulses=%0d at %0d expected 1 at 62", n_done, done_c); end
   endtask

   task automatic test_timeout();
      int e;
      res_limit = 10;
      run_layer(12'h020, 12'h200, 0);
      checks++; if (err_c !== 79 || busy_at_err !== 1'b0) begin failures++; $display("FAIL tmo_error: at %0d busy=%b expected 79/0", err_c, busy_at_err); end
      checks++; if (n_done !== 0) begin failures++; $display("FAIL tmo_no_done: got %0d expected 0", n_done); end
      e = out_errs(10);
      checks++; if (n_o !== 10 || e !== 0) begin failures++; $display("FAIL tmo_results: n=%0d bad=%0d expected 10/0", n_o, e); end
      checks++; if (error !== 1'b1) begin failures++; $display("FAIL tmo_sticky: error=%b expected 1", error); end
      res_limit = 25;
      run_layer(12'h020, 12'h200, 0);
      checks++; if (err_c !== -1 || n_done !== 1) begin failures++; $display("FAIL tmo_clear: error at %0d done=%0d expected none/1", err_c, n_done); end
   endtask

   task automatic test_reset_mid();
      int e;
      res_limit = 25;
      run_layer(12'h010, 12'h100, 2);
      checks++; if (rst_snap !== '0) begin failures++; $display("FAIL rst_mid: outputs=%h expected 0", rst_snap); end
      checks++; if (n_done !== 0 || n_o === 0) begin failures++; $display("FAIL rst_mid_pre: done=%0d out=%0d expected 0/>0", n_done, n_o); end
      @(negedge clk); rst_n = 1'b1;
      run_layer(12'h010, 12'h100, 0);
      e = out_errs(25);
      checks++; if (n_o !== 25 || e !== 0 || n_done !== 1) begin failures++; $display("FAIL rst_rerun: n=%0d bad=%0d done=%0d expected 25/0/1", n_o, e, n_done); end
   endtask

   task automatic test_wrap();
      int e;
      res_limit = 25;
      run_layer(12'hFFC, 12'hFF0, 0);
      e = addr_errs(12'hFFC, 12'hFF0);
      checks++; if (e !== 0 || n_addr !== 58) begin failures++; $display("FAIL wrap_addr: %0d bad of %0d reads, expected 0 of 58", e, n_addr); end
      checks++; if (addr_log[57] !== 12'h020) begin failures++; $display("FAIL wrap_last: got %h expected 020", addr_log[57]); end
      e = data_errs(12'hFFC, 12'hFF0);
      checks++; if (e !== 0) begin failures++; $display("FAIL wrap_data: %0d bad words, expected 0", e); end
      checks++; if (n_done !== 1 || err_c !== -1) begin failures++; $display("FAIL wrap_done: done=%0d error at %0d expected 1/none", n_done, err_c); end
   endtask

   task automatic test_spurious();
      int ov = 0;
      int e;
      @(negedge clk); spur = 1'b1;
      @(negedge clk); spur = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (out_valid) ov++;
         @(negedge clk);
      end
      checks++; if (ov !== 0) begin failures++; $display("FAIL spur_idle: %0d out_valid cycles expected 0", ov); end
      res_limit = 25;
      run_layer(12'h030, 12'h300, 3);
      spur = 1'b0;
      e = out_errs(25);
      checks++; if (n_o !== 25 || e !== 0) begin failures++; $display("FAIL spur_extra: n=%0d bad=%0d expected 25/0", n_o, e); end
      checks++; if (n_done !== 1 || done_c !== 62) begin failures++; $display("FAIL spur_done: pulses=%0d at %0d expected 1 at 62", n_done, done_c); end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_start_busy();
      test_timeout();
      test_reset_mid();
      test_wrap();
      test_spurious();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
